// File: rtl/vpipe_pkg.sv
// vpipe_pkg: shared state encoding, lane default and forward-select codes for the vector pipe controller.
package vpipe_pkg;
  typedef enum logic {RUN, MEM} state_t;
  localparam int LANES_DEF = 16;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the operand source for one execute-stage register read.
module forward_unit import vpipe_pkg::*; #(
  parameter int RW = 4
) (
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] wa_m,
  input  logic [RW-1:0] wa_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output logic [1:0]    fwd
);
  // M has the younger result, so it wins over W
  always_comb fwd = (reg_write_m && wa_m == ra) ? FWD_M :
                    (reg_write_w && wa_w == ra) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: hazard/forwarding control plus lane sequencer for vector loads and stores.
module pipe_controller import vpipe_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int RW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RW-1:0]            ra1D,
  input  logic [RW-1:0]            ra2D,
  input  logic [RW-1:0]            ra1E,
  input  logic [RW-1:0]            ra2E,
  input  logic [RW-1:0]            WA3E,
  input  logic [RW-1:0]            WA3M,
  input  logic [RW-1:0]            WA3W,
  input  logic                     RegWriteE,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     MemtoRegE,
  input  logic                     MemtoRegM,
  input  logic                     MemWriteM,
  input  logic                     mem_ack,
  output logic                     cargarF,
  output logic                     cargarD,
  output logic                     cargarE,
  output logic                     cargarM,
  output logic                     cargarW,
  output logic                     flushE,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic                     mem_req,
  output logic [$clog2(LANES)-1:0] lane_idx,
  output logic                     busy
);
  localparam int LW = $clog2(LANES);
  state_t state;
  logic lu, vec, last, adv;
  forward_unit #(.RW(RW)) u_fwd_a (
    .ra(ra1E), .wa_m(WA3M), .wa_w(WA3W),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardAE)
  );
  forward_unit #(.RW(RW)) u_fwd_b (
    .ra(ra2E), .wa_m(WA3M), .wa_w(WA3W),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardBE)
  );
  always_comb begin
    lu   = MemtoRegE && RegWriteE && (WA3E == ra1D || WA3E == ra2D);
    vec  = MemtoRegM || MemWriteM;
    last = lane_idx == LW'(LANES - 1);
    adv  = (state == RUN) ? !vec : (mem_ack && last);
  end
  // enables are gated by reset so an asserted reset freezes the pipe without waiting for a clock
  always_comb begin
    cargarF = reset && adv && !lu;
    cargarD = reset && adv && !lu;
    cargarE = reset && adv;
    cargarM = reset && adv;
    cargarW = reset && adv;
    flushE  = reset && adv && lu;
    mem_req = state == MEM;
    busy    = state == MEM;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      lane_idx <= '0;
    end else if (state == RUN) begin
      state    <= vec ? MEM : RUN;
      lane_idx <= '0;
    end else if (mem_ack) begin
      state    <= last ? RUN : MEM;
      lane_idx <= last ? '0 : lane_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed checks of forwarding, load-use stalls, lane sequencing and async reset.
module tb_pipe_controller;
  logic clk, reset;
  logic [3:0] ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, mem_ack;
  logic cargarF, cargarD, cargarE, cargarM, cargarW, flushE, mem_req, busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] lane_idx;
  logic [4:0] cg;
  int checks = 0, errors = 0;

  pipe_controller dut (
    .clk(clk), .reset(reset), .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .mem_ack(mem_ack), .cargarF(cargarF), .cargarD(cargarD), .cargarE(cargarE),
    .cargarM(cargarM), .cargarW(cargarW), .flushE(flushE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .mem_req(mem_req), .lane_idx(lane_idx), .busy(busy)
  );

  assign cg = {cargarF, cargarD, cargarE, cargarM, cargarW};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic ck(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [4:0] c, input logic f, input logic m, input logic [3:0] l);
    ck({tag, "_cargar"}, {3'b0, cg}, {3'b0, c});
    ck({tag, "_flushE"}, {7'b0, flushE}, {7'b0, f});
    ck({tag, "_mem_req"}, {7'b0, mem_req}, {7'b0, m});
    ck({tag, "_busy"}, {7'b0, busy}, {7'b0, m});
    ck({tag, "_lane"}, {4'b0, lane_idx}, {4'b0, l});
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset = 0;
    {ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, mem_ack} = '0;
    ra1E = 3; WA3M = 3; RegWriteM = 1;
    #1;
    ctl("reset", 5'b00000, 0, 0, 0);
    ck("fwd_in_reset", {6'b0, ForwardAE}, 8'h2);
    step; reset = 1;
    WA3W = 3; RegWriteW = 1; #1;
    ck("fwdA_M", {6'b0, ForwardAE}, 8'h2);
    RegWriteM = 0; #1;
    ck("fwdA_W", {6'b0, ForwardAE}, 8'h1);
    ra1E = 4; #1;
    ck("fwdA_RF", {6'b0, ForwardAE}, 8'h0);
    ra2E = 3; #1;
    ck("fwdB_W", {6'b0, ForwardBE}, 8'h1);
    ra2E = 7; WA3M = 7; RegWriteM = 1; #1;
    ck("fwdB_M", {6'b0, ForwardBE}, 8'h2);
    ctl("run_adv", 5'b11111, 0, 0, 0);
    step; MemtoRegE = 1; RegWriteE = 1; WA3E = 5; ra2D = 5; #1;
    ctl("lu_b", 5'b00111, 1, 0, 0);
    step; ra2D = 0; ra1D = 5; #1;
    ctl("lu_a", 5'b00111, 1, 0, 0);
    step; RegWriteE = 0; #1;
    ctl("no_lu", 5'b11111, 0, 0, 0);
    step; MemtoRegE = 0; ra1D = 0; mem_ack = 1; #1;
    ctl("ack_in_run", 5'b11111, 0, 0, 0);
    // vector load, acked every cycle: 1 detect + 16 lanes
    step; MemtoRegM = 1; #1;
    ctl("vld_detect", 5'b00000, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step; MemtoRegM = 0; #1;
      ctl($sformatf("vld_l%0d", i), (i == 15) ? 5'b11111 : 5'b00000, 0, 1, 4'(i));
    end
    step; mem_ack = 0; #1;
    ctl("vld_back_run", 5'b11111, 0, 0, 0);
    // vector store with ack low for 3 cycles at lane 4: 20 cycles total
    step; MemWriteM = 1; #1;
    ctl("vst_detect", 5'b00000, 0, 0, 0);
    for (int k = 0; k < 19; k++) begin
      step; MemWriteM = 0; mem_ack = !(k >= 4 && k <= 6); #1;
      ctl($sformatf("vst_k%0d", k), (k == 18) ? 5'b11111 : 5'b00000, 0, 1,
          4'(k < 4 ? k : (k <= 7 ? 4 : k - 3)));
    end
    step; #1;
    ctl("vst_back_run", 5'b11111, 0, 0, 0);
    // reset asserted mid-transfer at lane 9
    step; MemtoRegM = 1; mem_ack = 1; #1;
    ctl("rst_detect", 5'b00000, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step; MemtoRegM = 0; #1;
    end
    ctl("rst_l9", 5'b00000, 0, 1, 9);
    #2 reset = 0; #1;
    ctl("rst_async", 5'b00000, 0, 0, 0);
    step; reset = 1; mem_ack = 0; #1;
    ctl("rst_release", 5'b11111, 0, 0, 0);
    step; #1;
    ctl("rst_still_run", 5'b11111, 0, 0, 0);
    // final lane ack coincides with a load-use hazard
    step; MemtoRegM = 1; mem_ack = 1; #1;
    ctl("fin_detect", 5'b00000, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step; MemtoRegM = 0; #1;
    end
    step; MemtoRegE = 1; RegWriteE = 1; WA3E = 2; ra1D = 2; #1;
    ctl("fin_l15_lu", 5'b00111, 1, 1, 15);
    step; #1;
    ctl("fin_run_lu", 5'b00111, 1, 0, 0);
    step; MemtoRegE = 0; #1;
    ctl("fin_run_adv", 5'b11111, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
